// File: rtl/job_mgr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : job_mgr_pkg
//  Description : Shared types and constants for the job dispatcher: FSM state
//                encoding, completion status codes and descriptor beat width.
//  Revision    : 1.0 - initial release
// ============================================================================
package job_mgr_pkg;

    // One descriptor beat; a full descriptor is two beats.
    localparam int unsigned c_BEAT_W    = 512;
    localparam int unsigned c_PAYLOAD_W = 2 * c_BEAT_W;

    // Completion status codes. 2'b10 and 2'b11 are reserved.
    localparam logic [1:0] c_STATUS_OK      = 2'b00;
    localparam logic [1:0] c_STATUS_TIMEOUT = 2'b01;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BEAT1     = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        CPL       = 3'd4
    } state_t;

endpackage : job_mgr_pkg
`default_nettype wire

// File: rtl/job_timeout_timer.sv
`default_nettype none
// ============================================================================
//  Module      : job_timeout_timer
//  Description : Cycle counter for the WAIT_DONE phase. Counts from zero while
//                enabled; expired is high in the cycle the count equals
//                TIMEOUT_CYCLES-1. TIMEOUT_CYCLES == 0 never expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module job_timeout_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] r_count;

    // Free-running count while enabled; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= 32'd0;
        end else if (enable) begin
            r_count <= r_count + 32'd1;
        end
    end

    // The zero check keeps the wrapped TIMEOUT_CYCLES-1 from ever matching.
    assign expired = enable && (TIMEOUT_CYCLES != 32'd0) &&
                     (r_count == (TIMEOUT_CYCLES - 32'd1));

endmodule : job_timeout_timer
`default_nettype wire

// File: rtl/job_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : job_dispatcher
//  Description : Assembles a two-beat 1024-bit descriptor, starts one engine
//                job, waits for engine_done or a timeout, and hands off one
//                completion record. One job in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module job_dispatcher
    import job_mgr_pkg::*;
#(
    parameter int unsigned READREG_NUMBER = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           desc_valid,
    output logic                           desc_ready,
    input  logic [c_BEAT_W-1:0]            desc_data,
    output logic                           engine_start,
    output logic [c_PAYLOAD_W-1:0]         payload,
    input  logic                           engine_done,
    input  logic [READREG_NUMBER*32-1:0]   return_code,
    output logic                           cpl_valid,
    input  logic                           cpl_ready,
    output logic [15:0]                    cpl_job_id,
    output logic [1:0]                     cpl_status,
    output logic [READREG_NUMBER*32-1:0]   cpl_return_code,
    output logic                           busy,
    output logic [31:0]                    job_count
);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [c_PAYLOAD_W-1:0]         r_payload;
    logic [1:0]                     r_cpl_status;
    logic [READREG_NUMBER*32-1:0]   r_cpl_rc;
    logic [31:0]                    r_job_count;

    logic w_load_beat0;
    logic w_load_beat1;
    logic w_cap_ok;
    logic w_cap_timeout;
    logic w_cpl_hs;
    logic w_in_wait;
    logic w_expired;

    assign w_in_wait = (r_state == WAIT_DONE);

    job_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_in_wait),
        .enable  (w_in_wait),
        .expired (w_expired)
    );

    // State register; reset abandons any partial descriptor or running job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; engine_done is not looked at in START
    // because it can still be high from the previous job.
    always_comb begin
        w_state_next  = r_state;
        desc_ready    = 1'b0;
        engine_start  = 1'b0;
        cpl_valid     = 1'b0;
        w_load_beat0  = 1'b0;
        w_load_beat1  = 1'b0;
        w_cap_ok      = 1'b0;
        w_cap_timeout = 1'b0;
        w_cpl_hs      = 1'b0;
        case (r_state)
            IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    w_load_beat0 = 1'b1;
                    w_state_next = BEAT1;
                end
            end
            BEAT1: begin
                desc_ready = 1'b1;
                if (desc_valid) begin
                    w_load_beat1 = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                engine_start = 1'b1;
                w_state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (engine_done) begin
                    w_cap_ok     = 1'b1;
                    w_state_next = CPL;
                end else if (w_expired) begin
                    w_cap_timeout = 1'b1;
                    w_state_next  = CPL;
                end
            end
            CPL: begin
                cpl_valid = 1'b1;
                if (cpl_ready) begin
                    w_cpl_hs     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Descriptor assembly, completion capture and the handed-off job counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_payload    <= '0;
            r_cpl_status <= c_STATUS_OK;
            r_cpl_rc     <= '0;
            r_job_count  <= 32'd0;
        end else begin
            if (w_load_beat0) begin
                r_payload[c_BEAT_W-1:0] <= desc_data;
            end
            if (w_load_beat1) begin
                r_payload[c_PAYLOAD_W-1:c_BEAT_W] <= desc_data;
            end
            if (w_cap_ok) begin
                r_cpl_status <= c_STATUS_OK;
                r_cpl_rc     <= return_code;
            end else if (w_cap_timeout) begin
                r_cpl_status <= c_STATUS_TIMEOUT;
                r_cpl_rc     <= '0;
            end
            if (w_cpl_hs) begin
                r_job_count <= r_job_count + 32'd1;
            end
        end
    end

    assign payload         = r_payload;
    assign cpl_job_id      = r_payload[15:0];
    assign cpl_status      = r_cpl_status;
    assign cpl_return_code = r_cpl_rc;
    assign job_count       = r_job_count;
    assign busy            = (r_state != IDLE);

endmodule : job_dispatcher
`default_nettype wire

// File: doc/job_dispatcher.md
JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 SHALL have parameter READREG_NUMBER, default 1, number of 32-bit return-code words from the engine adaptor.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'h00FF_FFFF, cycles to wait for engine_done; 0 disables the timeout.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port desc_valid  in  1  descriptor beat valid.
REQ-006 SHALL have port desc_ready  out  1  descriptor beat accepted when high with desc_valid.
REQ-007 SHALL have port desc_data  in  512  descriptor beat; beat 0 = payload[511:0], beat 1 = payload[1023:512].
REQ-008 SHALL have port engine_start  out  1  one-cycle job start pulse to the AXI-Lite adaptor.
REQ-009 SHALL have port payload  out  1024  assembled descriptor to the adaptor.
REQ-010 SHALL have port engine_done  in  1  level from the adaptor; high once the job is finished and return words are read.
REQ-011 SHALL have port return_code  in  READREG_NUMBER*32  adaptor return words.
REQ-012 SHALL have ports cpl_valid out 1 / cpl_ready in 1, a completion handshake.
REQ-013 SHALL have ports cpl_job_id out 16, cpl_status out 2, cpl_return_code out READREG_NUMBER*32.
REQ-014 SHALL have ports busy out 1 (state != IDLE) and job_count out 32 (completions handed off).

Function
REQ-015 SHALL implement states IDLE, BEAT1, START, WAIT_DONE, CPL.
REQ-016 SHALL assert desc_ready only in IDLE and BEAT1.
REQ-017 SHALL, on an IDLE beat handshake, store payload[511:0] and go to BEAT1; on a BEAT1 handshake, store payload[1023:512] and go to START.
REQ-018 SHALL assert engine_start for exactly the one cycle in START, then go to WAIT_DONE; latency from the beat-1 handshake to engine_start is 1 cycle.
REQ-019 SHALL hold payload stable from the beat-1 handshake until the CPL handshake.
REQ-020 SHALL ignore engine_done during the START cycle, because it may still be high from the previous job.
REQ-021 SHALL, in WAIT_DONE with engine_done high, capture return_code into cpl_return_code, set cpl_status = 2'b00, and go to CPL.
REQ-022 SHALL count cycles in WAIT_DONE from 0; when the count reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0) and engine_done is low, set cpl_status = 2'b01, set cpl_return_code = 0, and go to CPL.
REQ-023 SHALL give engine_done priority over timeout when both occur in the same cycle.
REQ-024 SHALL drive cpl_job_id = payload[15:0].
REQ-025 SHALL assert cpl_valid only in CPL, holding all cpl_* outputs stable until cpl_ready.
REQ-026 SHALL, on the CPL handshake, increment job_count (wrapping 2^32-1 -> 0) and return to IDLE.
REQ-027 SHALL keep at most one job in flight; no beat is accepted from the beat-1 handshake until the CPL handshake.
REQ-028 SHALL reserve cpl_status codes 2'b10 and 2'b11 and never drive them.

Reset
REQ-029 SHALL, while rst is high, force state IDLE; desc_ready is then 1 per REQ-016, and engine_start=0, cpl_valid=0, busy=0, job_count=0, payload=0, cpl_status=0, cpl_return_code=0, timeout counter=0.
REQ-030 SHALL discard any partial descriptor or in-flight job on reset, with no completion produced for it.

Structure
REQ-031 SHALL place the state encoding, the cpl_status codes (OK=00, TIMEOUT=01) and the 512-bit beat width in the shared package job_mgr_pkg.
REQ-032 SHALL implement the WAIT_DONE cycle counter as the sub-module job_timeout_timer (inputs clear and enable; output expired).

Verification
REQ-033 SHALL cover: two beats (beat 0 = 512'h...0042) -> one engine_start pulse 1 cycle after beat 1, payload[15:0] = 16'h0042; engine_done with return_code = 32'hDEAD_BEEF -> cpl_job_id = 16'h0042, status 00, rc 32'hDEAD_BEEF, job_count = 1.
REQ-034 SHALL cover: engine_done held high from the prior job through the START cycle, then low -> no completion until engine_done rises again.
REQ-035 SHALL cover: TIMEOUT_CYCLES = 16, engine_done never asserted -> cpl_valid 16 cycles after entering WAIT_DONE, status 01, rc 0.
REQ-036 SHALL cover: engine_done rising in the same cycle the timeout expires -> status 00.
REQ-037 SHALL cover: cpl_ready low for 10 cycles while desc_valid is high -> desc_ready stays 0 and cpl_* stay stable; job_count preset to 32'hFFFF_FFFF -> 0 after the handshake.
REQ-038 SHALL cover: rst pulsed in BEAT1 and again in WAIT_DONE -> state IDLE, no cpl_valid, engine_start 0, next full descriptor processed normally.
